// File: rtl/iq_stream_join.sv
// iq_stream_join: recombines independent I and Q sample lanes into one
// complex stream {I, Q}. Each lane has its own elastic FIFO so path-delay
// skew between the lanes is absorbed. A drop engine can discard a number of
// samples from one lane to realign the pair. Output framing comes either from
// a samples-per-packet counter or from the merged input tlast.

// Per-lane elastic FIFO with a registered head stage.
// Entries land in storage first and move into the head register on the next
// edge, so a sample written at edge N is poppable during the cycle after N+1.
// level counts storage plus head. ready is derived from the registered level
// only, so a full FIFO that is popped this cycle still reports not-ready.
module iq_lane_fifo #(
    parameter int DW        = 17,
    parameter int FIFO_SIZE = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic [DW-1:0]        in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DW-1:0]        head_data,
    output logic                 head_valid,
    input  logic                 pop,
    output logic [FIFO_SIZE:0]   level
);

    localparam int DEPTH = 1 << FIFO_SIZE;
    localparam logic [FIFO_SIZE:0]   FULL_LEVEL = {1'b1, {FIFO_SIZE{1'b0}}};
    localparam logic [FIFO_SIZE-1:0] PTR_ONE    = {{(FIFO_SIZE-1){1'b0}}, 1'b1};

    logic [DW-1:0]        mem [DEPTH];
    logic [FIFO_SIZE-1:0] wr_ptr;
    logic [FIFO_SIZE-1:0] rd_ptr;
    logic [FIFO_SIZE:0]   mem_count;
    logic                 ready_en;
    logic                 push;
    logic                 load_head;

    assign level     = mem_count + {{FIFO_SIZE{1'b0}}, head_valid};
    assign in_ready  = ready_en && (level != FULL_LEVEL);
    assign push      = in_valid && in_ready && !clear;
    assign load_head = (mem_count != '0) && (!head_valid || pop);

    // Storage array write port; contents need no reset since pointers gate reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy and head register; clear flushes everything at once.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_count  <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
            ready_en   <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_count  <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
            ready_en   <= 1'b1;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (load_head) begin
                head_data  <= mem[rd_ptr];
                head_valid <= 1'b1;
                rd_ptr     <= rd_ptr + PTR_ONE;
            end else if (pop) begin
                head_valid <= 1'b0;
            end
            mem_count <= mem_count + {{FIFO_SIZE{1'b0}}, push}
                                   - {{FIFO_SIZE{1'b0}}, load_head};
        end
    end

endmodule

// Join / drop engine and output register.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  S_IDLE | pairs both lane heads into the output register when possible
//  S_DROP | discards heads of the selected lane until the counter expires
module iq_stream_join #(
    parameter int WIDTH     = 16,
    parameter int FIFO_SIZE = 5,
    parameter int SPP_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic [SPP_WIDTH-1:0]   spp,
    input  logic                   drop_stb,
    input  logic                   drop_lane,
    input  logic [SPP_WIDTH-1:0]   drop_count,
    input  logic [WIDTH-1:0]       i0_tdata,
    input  logic                   i0_tlast,
    input  logic                   i0_tvalid,
    output logic                   i0_tready,
    input  logic [WIDTH-1:0]       i1_tdata,
    input  logic                   i1_tlast,
    input  logic                   i1_tvalid,
    output logic                   i1_tready,
    output logic [2*WIDTH-1:0]     o_tdata,
    output logic                   o_tlast,
    output logic                   o_tvalid,
    input  logic                   o_tready,
    output logic [FIFO_SIZE:0]     lane0_level,
    output logic [FIFO_SIZE:0]     lane1_level,
    output logic                   drop_busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DROP = 1'b1
    } drop_state_t;

    localparam logic [SPP_WIDTH-1:0] CNT_ONE = {{(SPP_WIDTH-1){1'b0}}, 1'b1};

    drop_state_t            state;
    drop_state_t            state_next;
    logic [SPP_WIDTH-1:0]   drop_cnt;
    logic                   drop_lane_q;
    logic [SPP_WIDTH-1:0]   beat_cnt;

    logic [WIDTH:0]         h0_data;
    logic [WIDTH:0]         h1_data;
    logic                   h0_valid;
    logic                   h1_valid;
    logic                   pop0;
    logic                   pop1;
    logic                   join_pop;
    logic                   drop_pop;
    logic                   drop_start;
    logic                   spp_last;
    logic                   pair_last;

    iq_lane_fifo #(
        .DW        (WIDTH + 1),
        .FIFO_SIZE (FIFO_SIZE)
    ) u_lane0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .in_data    ({i0_tlast, i0_tdata}),
        .in_valid   (i0_tvalid),
        .in_ready   (i0_tready),
        .head_data  (h0_data),
        .head_valid (h0_valid),
        .pop        (pop0),
        .level      (lane0_level)
    );

    iq_lane_fifo #(
        .DW        (WIDTH + 1),
        .FIFO_SIZE (FIFO_SIZE)
    ) u_lane1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .in_data    ({i1_tlast, i1_tdata}),
        .in_valid   (i1_tvalid),
        .in_ready   (i1_tready),
        .head_data  (h1_data),
        .head_valid (h1_valid),
        .pop        (pop1),
        .level      (lane1_level)
    );

    assign drop_busy  = (state == S_DROP);
    assign drop_start = (state == S_IDLE) && drop_stb && (drop_count != '0);

    // Packet boundary from the beat counter; >= copes with spp shrinking mid-packet.
    assign spp_last  = (beat_cnt >= (spp - CNT_ONE));
    assign pair_last = (spp == '0) ? (h0_data[WIDTH] | h1_data[WIDTH]) : spp_last;

    // Drop engine state register.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and FIFO pop selection.
    always_comb begin
        state_next = state;
        join_pop   = 1'b0;
        drop_pop   = 1'b0;
        pop0       = 1'b0;
        pop1       = 1'b0;
        case (state)
            S_IDLE: begin
                join_pop = h0_valid && h1_valid && (!o_tvalid || o_tready);
                pop0     = join_pop;
                pop1     = join_pop;
                if (drop_start) begin
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                drop_pop = drop_lane_q ? h1_valid : h0_valid;
                pop0     = drop_pop && !drop_lane_q;
                pop1     = drop_pop && drop_lane_q;
                if (drop_pop && (drop_cnt == CNT_ONE)) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Drop down-counter and lane select, latched when a drop starts.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            drop_cnt    <= '0;
            drop_lane_q <= 1'b0;
        end else if (drop_start) begin
            drop_cnt    <= drop_count;
            drop_lane_q <= drop_lane;
        end else if (drop_pop) begin
            drop_cnt <= drop_cnt - CNT_ONE;
        end
    end

    // Output register and beat counter. tlast is decided when a beat is loaded
    // so it stays stable while the beat waits for o_tready.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tlast  <= 1'b0;
            beat_cnt <= '0;
        end else if (join_pop) begin
            o_tvalid <= 1'b1;
            o_tdata  <= {h0_data[WIDTH-1:0], h1_data[WIDTH-1:0]};
            o_tlast  <= pair_last;
            if ((spp == '0) || spp_last) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + CNT_ONE;
            end
        end else if (o_tready) begin
            o_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iq_stream_join.sv
// Directed bench for iq_stream_join: stimulus pushes expected joined beats
// into a queue, a negedge monitor pops and compares on every handshake.
module tb_iq_stream_join;

    localparam int WIDTH     = 16;
    localparam int FIFO_SIZE = 5;
    localparam int SPP_WIDTH = 16;

    logic                 clk;
    logic                 reset_n;
    logic                 clear;
    logic [SPP_WIDTH-1:0] spp;
    logic                 drop_stb;
    logic                 drop_lane;
    logic [SPP_WIDTH-1:0] drop_count;
    logic [WIDTH-1:0]     i0_tdata;
    logic                 i0_tlast;
    logic                 i0_tvalid;
    logic                 i0_tready;
    logic [WIDTH-1:0]     i1_tdata;
    logic                 i1_tlast;
    logic                 i1_tvalid;
    logic                 i1_tready;
    logic [2*WIDTH-1:0]   o_tdata;
    logic                 o_tlast;
    logic                 o_tvalid;
    logic                 o_tready;
    logic [FIFO_SIZE:0]   lane0_level;
    logic [FIFO_SIZE:0]   lane1_level;
    logic                 drop_busy;

    iq_stream_join #(
        .WIDTH     (WIDTH),
        .FIFO_SIZE (FIFO_SIZE),
        .SPP_WIDTH (SPP_WIDTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .spp         (spp),
        .drop_stb    (drop_stb),
        .drop_lane   (drop_lane),
        .drop_count  (drop_count),
        .i0_tdata    (i0_tdata),
        .i0_tlast    (i0_tlast),
        .i0_tvalid   (i0_tvalid),
        .i0_tready   (i0_tready),
        .i1_tdata    (i1_tdata),
        .i1_tlast    (i1_tlast),
        .i1_tvalid   (i1_tvalid),
        .i1_tready   (i1_tready),
        .o_tdata     (o_tdata),
        .o_tlast     (o_tlast),
        .o_tvalid    (o_tvalid),
        .o_tready    (o_tready),
        .lane0_level (lane0_level),
        .lane1_level (lane1_level),
        .drop_busy   (drop_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [32:0] exp_q[$];     // {tlast, {lane0, lane1}}
    logic [16:0] q0[$];        // lane0 stimulus {tlast, data}
    logic [16:0] q1[$];        // lane1 stimulus {tlast, data}

    bit   rdy_random = 1'b0;
    int   first_valid_cyc = -1;
    int   first_hs_cyc = 0;
    int   last_hs_cyc = 0;
    int   hs_count = 0;
    bit   stall_q = 1'b0;
    logic [32:0] hold_beat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Downstream ready: always 1 unless random backpressure is enabled.
    initial begin
        o_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            o_tready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compares every handshake against the scoreboard, enforces
    // hold-during-stall and the full-FIFO ready rule.
    always @(negedge clk) begin
        logic [32:0] e;
        if (!reset_n || clear) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_valid_held", o_tvalid, 1);
                check("stall_beat_held", {o_tlast, o_tdata}, hold_beat);
            end
            if (lane0_level == 6'd32) check("i0_ready_at_full", i0_tready, 0);
            if (lane1_level == 6'd32) check("i1_ready_at_full", i1_tready, 0);
            if (o_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (o_tvalid && o_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got 0x%0h, expected no beat", {o_tlast, o_tdata});
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {o_tlast, o_tdata}, e);
                end
                if (hs_count == 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                hs_count++;
            end
            stall_q   = o_tvalid && !o_tready;
            hold_beat = {o_tlast, o_tdata};
        end
    end

    // Drive both lanes from q0/q1 with handshakes; lane1 held off for lane1_delay cycles.
    task automatic drive_lanes(input int lane1_delay, output int first_acc1);
        int  k = 0;
        bit  a0, a1;
        first_acc1 = -1;
        while ((q0.size() > 0 || q1.size() > 0) && k < 3000) begin
            i0_tvalid = (q0.size() > 0);
            if (q0.size() > 0) {i0_tlast, i0_tdata} = q0[0];
            i1_tvalid = (q1.size() > 0) && (k >= lane1_delay);
            if (q1.size() > 0) {i1_tlast, i1_tdata} = q1[0];
            @(negedge clk);
            a0 = i0_tvalid && i0_tready;
            a1 = i1_tvalid && i1_tready;
            if (a1 && first_acc1 < 0) first_acc1 = cyc + 1;
            @(posedge clk);
            #1;
            if (a0) void'(q0.pop_front());
            if (a1) void'(q1.pop_front());
            k++;
        end
        i0_tvalid = 1'b0;
        i1_tvalid = 1'b0;
        check("drive_completed", (q0.size() + q1.size()), 0);
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((exp_q.size() > 0 || o_tvalid) && k < 600) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic start_drop(input logic lane, input int count);
        drop_stb   = 1'b1;
        drop_lane  = lane;
        drop_count = SPP_WIDTH'(count);
        @(posedge clk);
        #1;
        drop_stb = 1'b0;
    endtask

    task automatic reset_monitor_stats();
        first_valid_cyc = -1;
        hs_count = 0;
    endtask

    // Queue n pairs: lane0 = base0+n, lane1 = base1+n, optional random input
    // tlasts, expected tlast from the given bit mask over beat indices.
    task automatic queue_pairs(input int n, input int base0, input int base1,
                               input bit rand_last, input logic [15:0] last_mask);
        logic l0, l1;
        for (int i = 0; i < n; i++) begin
            l0 = rand_last ? 1'($urandom_range(0, 1)) : 1'b0;
            l1 = rand_last ? 1'($urandom_range(0, 1)) : 1'b0;
            q0.push_back({l0, 16'(base0 + i)});
            q1.push_back({l1, 16'(base1 + i)});
            exp_q.push_back({last_mask[i], 16'(base0 + i), 16'(base1 + i)});
        end
    endtask

    initial begin
        int fa;
        int acc;
        int busy_cycles;
        bit a;

        reset_n = 1'b0;
        clear = 1'b0;
        spp = '0;
        drop_stb = 1'b0;
        drop_lane = 1'b0;
        drop_count = '0;
        i0_tdata = '0; i0_tlast = 1'b0; i0_tvalid = 1'b0;
        i1_tdata = '0; i1_tlast = 1'b0; i1_tvalid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_o_tvalid", o_tvalid, 0);
        check("rst_o_tlast", o_tlast, 0);
        check("rst_o_tdata", o_tdata, 0);
        check("rst_levels", {lane0_level, lane1_level}, 0);
        check("rst_drop_busy", drop_busy, 0);
        check("rst_treadys", {i0_tready, i1_tready}, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_treadys", {i0_tready, i1_tready}, 2'b11);

        // Balanced stream: 100 beats, single tlast from lane0 on the last one.
        reset_monitor_stats();
        for (int n = 0; n < 100; n++) begin
            q0.push_back({(n == 99), 16'(n)});
            q1.push_back({1'b0, 16'(16'h8000 + n)});
            exp_q.push_back({(n == 99), 16'(n), 16'(16'h8000 + n)});
        end
        drive_lanes(0, fa);
        wait_drain("balanced_drain");
        check("balanced_latency", first_valid_cyc - fa, 2);
        check("balanced_beats", hs_count, 100);
        check("balanced_throughput", last_hs_cyc - first_hs_cyc, 99);

        // Skew: lane0 alone 10 samples, then lane1 catches up.
        reset_monitor_stats();
        for (int n = 0; n < 10; n++) q0.push_back({1'b0, 16'(n)});
        drive_lanes(0, fa);
        repeat (2) @(posedge clk);
        #1;
        check("skew_lane0_level", lane0_level, 10);
        check("skew_no_output", o_tvalid, 0);
        for (int n = 10; n < 20; n++) q0.push_back({1'b0, 16'(n)});
        for (int n = 0; n < 20; n++) begin
            q1.push_back({1'b0, 16'(16'h4000 + n)});
            exp_q.push_back({1'b0, 16'(n), 16'(16'h4000 + n)});
        end
        drive_lanes(0, fa);
        wait_drain("skew_drain");
        check("skew_latency", first_valid_cyc - fa, 2);

        // Drop with count 0 is a no-op.
        start_drop(1'b0, 0);
        check("drop0_noop", drop_busy, 0);

        // Drop 3 from lane1 preloaded with 0..9, then feed lane0 0..9.
        for (int n = 0; n < 10; n++) q1.push_back({1'b0, 16'(n)});
        drive_lanes(0, fa);
        repeat (2) @(posedge clk);
        #1;
        check("drop_preload_level", lane1_level, 10);
        start_drop(1'b1, 3);
        busy_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (drop_busy) busy_cycles++;
            @(posedge clk);
            #1;
        end
        check("drop_busy_cycles", busy_cycles, 3);
        check("drop_lane1_level", lane1_level, 7);
        for (int n = 0; n < 10; n++) q0.push_back({1'b0, 16'(n)});
        for (int n = 0; n < 7; n++) exp_q.push_back({1'b0, 16'(n), 16'(n + 3)});
        drive_lanes(0, fa);
        wait_drain("drop_drain");
        repeat (2) @(posedge clk);
        #1;
        check("drop_lane0_left", lane0_level, 3);
        check("drop_lane1_left", lane1_level, 0);
        pulse_clear();
        check("clear_levels", {lane0_level, lane1_level}, 0);

        // SPP framing: spp=4 over 10 beats with random input tlasts.
        spp = 16'd4;
        queue_pairs(10, 16'h0100, 16'h0200, 1'b1, 16'b0000_0000_1000_1000);
        drive_lanes(0, fa);
        wait_drain("spp4_drain");
        pulse_clear();
        // 12-beat run, spp reduced to 2 before beat 9 is formed.
        queue_pairs(9, 16'h0300, 16'h0400, 1'b1, 16'b0000_0000_1000_1000);
        drive_lanes(0, fa);
        wait_drain("spp_run_a_drain");
        spp = 16'd2;
        queue_pairs(3, 16'h0309, 16'h0409, 1'b1, 16'b0000_0000_0000_0101);
        drive_lanes(0, fa);
        wait_drain("spp_run_b_drain");
        spp = '0;
        pulse_clear();

        // Backpressure: fill lane0 to full, then drain with random o_tready.
        acc = 0;
        i0_tlast = 1'b0;
        i0_tvalid = 1'b1;
        for (int i = 0; i < 45; i++) begin
            i0_tdata = 16'(acc);
            @(negedge clk);
            a = i0_tready;
            @(posedge clk);
            #1;
            if (a) acc++;
        end
        i0_tvalid = 1'b0;
        check("bp_accepted", acc, 32);
        check("bp_lane0_full", lane0_level, 32);
        check("bp_ready_low", i0_tready, 0);
        rdy_random = 1'b1;
        for (int n = 0; n < 32; n++) begin
            q1.push_back({1'b0, 16'(16'h0100 + n)});
            exp_q.push_back({1'b0, 16'(n), 16'(16'h0100 + n)});
        end
        drive_lanes(0, fa);
        wait_drain("bp_drain");
        rdy_random = 1'b0;
        @(posedge clk);
        #1;

        // Abort: clear during DROP.
        start_drop(1'b1, 5);
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_before", drop_busy, 1);
        pulse_clear();
        check("abort_busy_cleared", drop_busy, 0);
        // A pair after the clear must be joined, not dropped.
        queue_pairs(1, 16'h0aaa, 16'h0bbb, 1'b0, 16'b0);
        drive_lanes(0, fa);
        wait_drain("abort_clear_pair");

        // Abort: reset mid-packet (and mid-drop) with spp=4.
        spp = 16'd4;
        queue_pairs(2, 16'h0c00, 16'h0d00, 1'b0, 16'b0);
        drive_lanes(0, fa);
        wait_drain("abort_partial_drain");
        start_drop(1'b0, 2);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_rst_busy", drop_busy, 0);
        check("abort_rst_levels", {lane0_level, lane1_level}, 0);
        check("abort_rst_valid", o_tvalid, 0);
        check("abort_rst_data", {o_tlast, o_tdata}, 0);
        reset_n = 1'b1;
        queue_pairs(4, 16'h0e00, 16'h0f00, 1'b1, 16'b0000_0000_0000_1000);
        drive_lanes(0, fa);
        wait_drain("abort_fresh_packet");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/iq_stream_join.md
# iq_stream_join

Recombines two independent 16-bit sample lanes (I and Q) into one 32-bit complex AXI-stream. This is the join-side counterpart of the lane splitter used ahead of the per-lane delay lines in the delay NoC block. Each lane has its own elastic FIFO to absorb path-delay mismatch. A drop engine discards a programmable number of samples from one lane to realign the lanes. Output framing either comes from a built-in samples-per-packet counter or from the merged input tlast.

## Interface
- WIDTH, 16, per-lane sample width
- FIFO_SIZE, 5, log2 of per-lane FIFO depth (depth = 2**FIFO_SIZE)
- SPP_WIDTH, 16, width of spp and drop_count

- clk  in  1  block clock; all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- clear  in  1  synchronous active-high flush
- spp  in  SPP_WIDTH  output samples per packet; 0 = pass-through tlast mode
- drop_stb  in  1  start drop operation
- drop_lane  in  1  0 = drop from lane 0 (I), 1 = drop from lane 1 (Q)
- drop_count  in  SPP_WIDTH  number of samples to discard
- i0_tdata/i0_tlast/i0_tvalid  in  WIDTH/1/1  lane 0 (I) input
- i0_tready  out  1  lane 0 ready
- i1_tdata/i1_tlast/i1_tvalid  in  WIDTH/1/1  lane 1 (Q) input
- i1_tready  out  1  lane 1 ready
- o_tdata  out  2*WIDTH  joined sample {lane0, lane1}
- o_tlast/o_tvalid  out  1/1  joined stream framing and valid
- o_tready  in  1  downstream ready
- lane0_level, lane1_level  out  FIFO_SIZE+1  per-lane FIFO occupancy
- drop_busy  out  1  drop engine active

## Operation
- **Lane FIFOs.** Each lane writes {tlast, tdata} into its own FIFO.
  - ix_tready = FIFO not full.
  - A FIFO is full at exactly 2**FIFO_SIZE entries.
- **Join.** The drop engine states are IDLE and DROP.
  - In IDLE, both FIFO heads are popped together when both are valid and the output register is empty or being consumed (o_tvalid & o_tready).
  - The popped pair is loaded into the single output register as o_tdata = {lane0, lane1}.
  - In DROP, no joined beat is produced.
- **Drop engine.**
  - IDLE → DROP on drop_stb with drop_count ≠ 0; the counter loads drop_count. drop_stb with count 0 is a no-op.
  - In DROP, the selected lane's FIFO head is popped on every cycle it is valid, and the counter decrements.
  - The pop that brings the counter from 1 to 0 returns the engine to IDLE on the next edge.
  - drop_stb is ignored while in DROP.
  - The tlast of discarded samples is discarded.
  - The other lane keeps filling and is back-pressured normally.
- **Framing, spp = 0.** o_tlast = lane0 tlast | lane1 tlast of the joined pair.
- **Framing, spp ≠ 0.**
  - Input tlasts are ignored.
  - A beat counter increments on each output handshake.
  - o_tlast is asserted on the beat where count ≥ spp−1, and the counter then resets to 0. The ≥ compare handles spp being reduced mid-packet.
  - Changing spp between 0 and nonzero takes effect on the next beat.
- **clear.** Empties both FIFOs and the output register, zeroes the beat counter and forces IDLE, all at the same edge. Inputs presented in that cycle are discarded.
- **Reset values.** All outputs go to zero: o_tvalid=0, o_tlast=0, o_tdata=0, levels=0, drop_busy=0. ix_tready=0 while reset_n is low and 1 on the first cycle after release.

## Timing
- Latency: a pair accepted on both lanes at edge N gives o_tvalid=1 after edge N+2, provided the output is not stalled.
- Throughput is 1 joined beat per cycle when both lanes are valid and o_tready=1.
- The output register holds o_tdata/o_tlast stable while o_tvalid & !o_tready (AXI rule). o_tvalid never drops without a handshake.
- Simultaneous push and pop on a FIFO leaves its level unchanged. A full FIFO with a pop in the same cycle still reports ix_tready=0 (ready is registered from level).
- drop_busy is high from the edge after drop_stb until the edge after the final discard.
- reset_n or clear asserted mid-drop or mid-packet aborts the operation. The next beat starts a fresh packet.

## Test plan
1. **Balanced stream.** Lane0 = n, lane1 = 0x8000+n for n = 0..99, spp = 0, lane0 tlast on n = 99 → 100 beats {n, 0x8000+n}; single o_tlast on beat 99; first o_tvalid 2 cycles after the first accept; one beat per cycle thereafter.
2. **Skew absorption.** Lane1 starts 10 cycles after lane0 → lane0_level peaks at 10, output starts 2 cycles after the first lane1 accept, no sample lost or reordered.
3. **Drop.** Both lanes preloaded 0..9, drop_lane = 1, drop_count = 3 → drop_busy high 3 cycles; output {0,3}, {1,4} … {6,9}; lane0_level ends at 3.
4. **SPP framing.** spp = 4, 10 beats, random input tlasts → o_tlast on beats 3 and 7 only. Set spp = 2 at beat 9 of a 12-beat run → tlast on beat 9.
5. **Backpressure.** o_tready 50% random, FIFO_SIZE = 5, lane0 driven continuously → i0_tready low when lane0_level = 32; o_tdata stable during stalls; order preserved.
6. **Abort.** clear during DROP, then reset_n low 1 cycle mid-packet with spp = 4 → drop_busy = 0, levels = 0, o_tvalid = 0; the next 4 beats end with tlast on the 4th.
